ofifo_col: RTL

- Column-wise output FIFO directly downstream of the SFP accumulate/ReLU stage.
- Each column has its own write enable, driven by the per-column write strobes from the SFP (wr_ofifo) and the packed accumulator outputs.
- Columns are read out together as one full row once every column holds at least one entry. The row goes to the output SRAM write path / testbench drain.
- Absorbs column skew from the systolic array so downstream logic sees aligned rows.

---
 rtl/ofifo_col_if.sv | 27 ++
 rtl/ofifo_col.sv | 94 +++++++++
 2 files changed

// File: rtl/ofifo_col_if.sv
// rtl/ofifo_col_if.sv - Row-aligned column FIFO bus: column writes in, row reads and status out
//   master : drives in/wr/rd, observes out/o_rd_valid/o_valid/o_full/o_ready/o_overflow
//   slave  : the FIFO itself, the opposite directions
interface ofifo_col_if #(
    parameter int col     = 8,
    parameter int psum_bw = 16
);
    logic [psum_bw*col-1:0] in;
    logic [col-1:0]         wr;
    logic                   rd;
    logic [psum_bw*col-1:0] out;
    logic                   o_rd_valid;
    logic                   o_valid;
    logic                   o_full;
    logic                   o_ready;
    logic                   o_overflow;

    modport master (
        output in, wr, rd,
        input  out, o_rd_valid, o_valid, o_full, o_ready, o_overflow
    );

    modport slave (
        input  in, wr, rd,
        output out, o_rd_valid, o_valid, o_full, o_ready, o_overflow
    );
endinterface

// File: rtl/ofifo_col.sv
// rtl/ofifo_col.sv - Column-wise output FIFO that realigns skewed column writes into full rows
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : ofifo_col_if.slave
//           in/wr        per-column data and write enables
//           rd           row read request, accepted only while o_valid
//           out          registered row, loaded one cycle after an accepted read
//           o_rd_valid   one-cycle pulse marking a freshly loaded out
//           o_valid      every column holds at least one entry
//           o_full       some column is full; o_ready is its inverse
//           o_overflow   sticky flag for a write attempted into a full column
module ofifo_col #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64,
    parameter int ptr_bw  = $clog2(depth)
) (
    input  logic        clk,
    input  logic        reset,
    ofifo_col_if.slave  bus
);
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ptr_bw:0]        wp [col];
    logic [ptr_bw:0]        rp;
    logic [psum_bw-1:0]     mem [col][depth];

    logic [col-1:0]         empty;
    logic [col-1:0]         full;
    logic [col-1:0]         wr_ok;
    logic                   valid;
    logic                   rd_ok;

    logic [psum_bw*col-1:0] out_q;
    logic                   rd_valid_q;
    logic                   overflow_q;

    always_comb begin
        empty = '0;
        full  = '0;
        for (int k = 0; k < col; k++) begin
            empty[k] = (wp[k] == rp);
            full[k]  = (wp[k][ptr_bw-1:0] == rp[ptr_bw-1:0]) && (wp[k][ptr_bw] != rp[ptr_bw]);
        end
    end

    assign valid = &(~empty);
    // A lane full at cycle start refuses its write even if the same cycle pops it.
    assign wr_ok = bus.wr & ~full;
    assign rd_ok = bus.rd & valid;

    assign bus.o_valid    = valid;
    assign bus.o_full     = |full;
    assign bus.o_ready    = ~(|full);
    assign bus.out        = out_q;
    assign bus.o_rd_valid = rd_valid_q;
    assign bus.o_overflow = overflow_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < col; k++) begin
                wp[k] <= '0;
            end
            rp         <= '0;
            out_q      <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_ok;
            for (int k = 0; k < col; k++) begin
                if (wr_ok[k]) begin
                    wp[k] <= wp[k] + (ptr_bw+1)'(1);
                end
                if (bus.wr[k] && full[k]) begin
                    overflow_q <= 1'b1;
                end
            end
            if (rd_ok) begin
                rp <= rp + (ptr_bw+1)'(1);
                for (int k = 0; k < col; k++) begin
                    out_q[k*psum_bw +: psum_bw] <= mem[k][rp[ptr_bw-1:0]];
                end
            end
        end
    end

    // Storage has no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        for (int k = 0; k < col; k++) begin
            if (wr_ok[k]) begin
                mem[k][wp[k][ptr_bw-1:0]] <= bus.in[k*psum_bw +: psum_bw];
            end
        end
    end
endmodule
